// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The ovf line exists only when SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             done_valid;
    logic             done_ready;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    // slave: the subtractor; master: operand source plus result consumer
    modport slave (
        input  start_valid, a, b, done_ready,
        output start_ready, diff, borrow, done_valid
`ifdef SUB_OVF_EN
        , output ovf
`endif
    );

    modport master (
        output start_valid, a, b, done_ready,
        input  start_ready, diff, borrow, done_valid
`ifdef SUB_OVF_EN
        , input  ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b), one bit per clock.
// Define SUB_OVF_EN to add the registered signed-overflow flag (ovf).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
`ifdef SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    logic x, y, d, br_nxt;

    always_comb begin
        x      = a_sh[0];
        y      = b_sh[0];
        d      = x ^ y ^ br;
        br_nxt = (~x & y) | (~(x ^ y) & br);
    end

    // The accepting edge counts as the first of WIDTH+1 edges; the last
    // SHIFT edge commits borrow/ovf and raises done_valid together.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every state bit, including the operand shift registers, is
        // cleared on reset so a mid-operation abort leaves nothing stale.
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            a_sh            <= '0;
            b_sh            <= '0;
            br              <= 1'b0;
            bus.start_ready <= 1'b1;
            bus.done_valid  <= 1'b0;
            bus.diff        <= '0;
            bus.borrow      <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb           <= 1'b0;
            b_msb           <= 1'b0;
            bus.ovf         <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_sh            <= bus.a;
                        b_sh            <= bus.b;
                        br              <= 1'b0;
                        cnt             <= '0;
                        bus.start_ready <= 1'b0;
                        state           <= SHIFT;
`ifdef SUB_OVF_EN
                        a_msb           <= bus.a[WIDTH-1];
                        b_msb           <= bus.b[WIDTH-1];
`endif
                    end
                end

                SHIFT: begin
                    bus.diff <= {d, bus.diff[WIDTH-1:1]};
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    br       <= br_nxt;
                    cnt      <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.borrow     <= br_nxt;
                        bus.done_valid <= 1'b1;
                        cnt            <= '0;
                        state          <= DONE;
`ifdef SUB_OVF_EN
                        // d is the result MSB being shifted in on this edge
                        bus.ovf        <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end

                DONE: begin
                    if (bus.done_ready) begin
                        bus.done_valid  <= 1'b0;
                        bus.start_ready <= 1'b1;
                        state           <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
